// File: rtl/seg7_reader_pkg.sv
// Shared constants for the 7-segment read-back path.
// Segment patterns are [0:6] = a..g, lit = 1.
package seg7_reader_pkg;

  localparam logic [0:6] SEG_0     = 7'b1111110;
  localparam logic [0:6] SEG_1     = 7'b0110000;
  localparam logic [0:6] SEG_2     = 7'b1101101;
  localparam logic [0:6] SEG_3     = 7'b1111001;
  localparam logic [0:6] SEG_4     = 7'b0110011;
  localparam logic [0:6] SEG_5     = 7'b1011011;
  localparam logic [0:6] SEG_6     = 7'b1011111;
  localparam logic [0:6] SEG_7     = 7'b1110000;
  localparam logic [0:6] SEG_8     = 7'b1111111;
  localparam logic [0:6] SEG_9     = 7'b1111011;
  localparam logic [0:6] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/seg7_to_bcd.sv
// Segment pattern (lit = 1) to BCD digit decoder.
// Flags the all-off pattern and anything that is not 0-9.
module seg7_to_bcd
  import seg7_reader_pkg::*;
(
  input  logic [0:6] seg,
  output logic [3:0] digit,
  output logic       is_blank,
  output logic       is_bad
);

  // Inverse of the BCD -> segment table
  always_comb begin
    digit    = 4'd0;
    is_blank = 1'b0;
    is_bad   = 1'b0;
    unique case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads a 7-segment bus back into a BCD digit.
// Debounces, decodes, and offers the digit on valid/ready.
module seg7_reader
  import seg7_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
)(
  input  logic       KEY_3,
  input  logic       SW17,
  input  logic [0:6] segments,
  input  logic       dig_ready,
  output logic       W,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       dig_valid,
  output logic       blank,
  output logic       bad_pulse,
  output logic [3:0] err_cnt
);

  localparam logic [0:6] OFF_RAW =
    ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  logic [0:6] sync1;
  logic [0:6] sync2;
  logic [0:6] seg_s;
  logic [0:6] cand;
  logic [1:0] state;
  logic [7:0] cnt;
  logic [3:0] bcd;
  logic [3:0] dec_digit;
  logic       dec_blank;
  logic       dec_bad;
  logic       same;
  logic       settled;
  logic       can_load;
  logic       accept;

  assign seg_s    = ACTIVE_LOW ? ~sync2 : sync2;
  assign same     = (seg_s == cand);
  assign settled  = (state == ST_SETTLE) && same
                 && (cnt == CNT_MAX);
  assign can_load = !dig_valid || dig_ready;
  // A digit waits for the consumer; blank/bad never stall
  assign accept   = settled
                 && (dec_blank || dec_bad || can_load);

  assign {W, X, Y, Z} = bcd;

  seg7_to_bcd u_dec (
    .seg      (cand),
    .digit    (dec_digit),
    .is_blank (dec_blank),
    .is_bad   (dec_bad)
  );

  // Two-flop synchronizer for the asynchronous bus
  always_ff @(posedge KEY_3) begin
    if (!SW17) begin
      sync1 <= OFF_RAW;
      sync2 <= OFF_RAW;
    end else begin
      sync1 <= segments;
      sync2 <= sync1;
    end
  end

  // Settle FSM: track candidate pattern and its stable run
  always_ff @(posedge KEY_3) begin
    if (!SW17) begin
      state <= ST_IDLE;
      cand  <= SEG_BLANK;
      cnt   <= 8'd0;
    end else if (!same) begin
      cand  <= seg_s;
      cnt   <= 8'd1;
      state <= ST_SETTLE;
    end else if (state == ST_SETTLE) begin
      if (cnt < CNT_MAX)
        cnt <= cnt + 8'd1;
      else if (accept)
        state <= ST_LOCKED;
    end
  end

  // Output regs, handshake and saturating error count
  always_ff @(posedge KEY_3) begin
    if (!SW17) begin
      bcd       <= 4'd0;
      dig_valid <= 1'b0;
      blank     <= 1'b1;
      bad_pulse <= 1'b0;
      err_cnt   <= 4'd0;
    end else begin
      bad_pulse <= 1'b0;
      if (dig_valid && dig_ready)
        dig_valid <= 1'b0;
      if (accept) begin
        unique case (1'b1)
          dec_bad: begin
            bad_pulse <= 1'b1;
            if (err_cnt != 4'hF)
              err_cnt <= err_cnt + 4'd1;
          end
          dec_blank: blank <= 1'b1;
          default: begin
            bcd       <= dec_digit;
            dig_valid <= 1'b1;
            blank     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader.
// Reference model works on run lengths of the sampled pattern.
module tb_seg7_reader;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dig_ready;
  logic [0:6] seg;
  logic [0:6] seg1;

  logic       W, X, Y, Z, dig_valid, blank, bad_pulse;
  logic [3:0] err_cnt;
  logic       W1, X1, Y1, Z1, dig_valid1, blank1, bad_pulse1;
  logic [3:0] err_cnt1;

  logic [10:0] obs;
  logic [10:0] obs1;
  assign obs  = {W, X, Y, Z, dig_valid, blank, bad_pulse, err_cnt};
  assign obs1 = {W1, X1, Y1, Z1, dig_valid1, blank1, bad_pulse1,
                 err_cnt1};

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b0)) dut (
    .KEY_3(clk), .SW17(rst_n), .segments(seg),
    .dig_ready(dig_ready),
    .W(W), .X(X), .Y(Y), .Z(Z),
    .dig_valid(dig_valid), .blank(blank),
    .bad_pulse(bad_pulse), .err_cnt(err_cnt)
  );

  seg7_reader #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b1)) dut_al (
    .KEY_3(clk), .SW17(rst_n), .segments(seg1),
    .dig_ready(dig_ready),
    .W(W1), .X(X1), .Y(Y1), .Z(Z1),
    .dig_valid(dig_valid1), .blank(blank1),
    .bad_pulse(bad_pulse1), .err_cnt(err_cnt1)
  );

  int checks = 0;
  int errors = 0;

  logic [0:6] tbl [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  // model state (active-high DUT)
  logic [0:6] q [$];
  logic [0:6] prev;
  int         run;
  bit         emitted;
  bit         m_valid;
  logic [3:0] m_dig;
  bit         m_blank;
  bit         m_bad;
  int         m_err;

  function automatic int classify(logic [0:6] p);
    if (p == 7'b0000000) return 10;
    for (int d = 0; d < 10; d++)
      if (p == tbl[d]) return d;
    return 11;
  endfunction

  function automatic logic [10:0] exp_vec();
    return {m_dig, m_valid, m_blank, m_bad, 4'(m_err)};
  endfunction

  task automatic model_reset();
    q = '{7'b0000000, 7'b0000000};
    prev = 7'b0000000;
    run = 0;
    emitted = 1'b1;
    m_valid = 1'b0;
    m_dig = 4'd0;
    m_blank = 1'b1;
    m_bad = 1'b0;
    m_err = 0;
  endtask

  // one clock edge: advance the model with the inputs seen there
  task automatic step();
    logic [0:6] s;
    int c;
    bit load;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      s = q.pop_front();
      q.push_back(seg);
      load = 1'b0;
      m_bad = 1'b0;
      if (s != prev) begin
        prev = s;
        run = 1;
        emitted = 1'b0;
      end else if (!emitted) begin
        run++;
      end
      if (!emitted && run > SC) begin
        c = classify(s);
        if (c == 11) begin
          m_bad = 1'b1;
          if (m_err < 15) m_err++;
          emitted = 1'b1;
        end else if (c == 10) begin
          m_blank = 1'b1;
          emitted = 1'b1;
        end else if (!m_valid || dig_ready) begin
          m_dig = 4'(c);
          m_blank = 1'b0;
          load = 1'b1;
          emitted = 1'b1;
        end
      end
      if (load) m_valid = 1'b1;
      else if (dig_ready) m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seg = 7'b0000000;
    seg1 = 7'b1111111;
    dig_ready = 1'b0;
    step();
    step();
    checks++;
    if (obs !== 11'b0000_0_1_0_0000) begin
      errors++;
      $display("FAIL reset got=%b want=%b", obs, 11'b0000_0_1_0_0000);
    end
    checks++;
    if (obs1 !== 11'b0000_0_1_0_0000) begin
      errors++;
      $display("FAIL reset_al got=%b want=%b", obs1,
               11'b0000_0_1_0_0000);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int nv = 0;
    int first = -1;
    logic [3:0] got = 4'd0;
    dig_ready = 1'b1;
    seg = 7'b1011011;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL single i=%0d got=%b want=%b", i, obs, exp_vec());
      end
      if (dig_valid === 1'b1) begin
        nv++;
        if (first < 0) begin
          first = i;
          got = {W, X, Y, Z};
        end
      end
    end
    checks++;
    if (nv != 1 || first != SC + 2 || got !== 4'b0101) begin
      errors++;
      $display("FAIL single_latency pulses=%0d at=%0d wxyz=%b want 1/%0d/0101",
               nv, first, got, SC + 2);
    end
  endtask

  task automatic test_glitch();
    int nv = 0;
    int nv8 = 0;
    dig_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      seg = ((i / 3) % 2 == 0) ? 7'b0110000 : 7'b1111111;
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL glitch i=%0d got=%b want=%b", i, obs, exp_vec());
      end
      if (dig_valid === 1'b1) nv++;
    end
    seg = 7'b1111111;
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_hold i=%0d got=%b want=%b", i, obs,
                 exp_vec());
      end
      if (dig_valid === 1'b1 && {W, X, Y, Z} === 4'b1000) nv8++;
    end
    checks++;
    if (nv != 0 || nv8 != 1) begin
      errors++;
      $display("FAIL glitch_count toggling=%0d eights=%0d want 0/1",
               nv, nv8);
    end
  endtask

  task automatic test_back_to_back();
    dig_ready = 1'b0;
    seg = 7'b1111001;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL bp3 i=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
    seg = 7'b1110000;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL bp7 i=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
    checks++;
    if ({W, X, Y, Z, dig_valid} !== 5'b0011_1) begin
      errors++;
      $display("FAIL bp_hold got=%b want=00111", {W, X, Y, Z, dig_valid});
    end
    dig_ready = 1'b1;
    step();
    checks++;
    if ({W, X, Y, Z, dig_valid} !== 5'b0111_1) begin
      errors++;
      $display("FAIL bp_swap got=%b want=01111", {W, X, Y, Z, dig_valid});
    end
    step();
    checks++;
    if (dig_valid !== 1'b0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL bp_drain got=%b want=%b", obs, exp_vec());
    end
  endtask

  task automatic test_bad();
    int pulses = 0;
    int blanks_ok = 0;
    dig_ready = 1'b1;
    for (int n = 0; n < 17; n++) begin
      seg = 7'b1000001;
      for (int i = 0; i < 8; i++) begin
        step();
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL bad n=%0d i=%0d got=%b want=%b", n, i, obs,
                   exp_vec());
        end
        if (bad_pulse === 1'b1) pulses++;
      end
      seg = 7'b0000000;
      for (int i = 0; i < 8; i++) begin
        step();
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL bad_blank n=%0d i=%0d got=%b want=%b", n, i,
                   obs, exp_vec());
        end
        if (bad_pulse === 1'b1) pulses++;
      end
      if (blank === 1'b1) blanks_ok++;
    end
    checks++;
    if (pulses != 17 || err_cnt !== 4'd15 || blanks_ok != 17) begin
      errors++;
      $display("FAIL bad_sat pulses=%0d err=%0d blanks=%0d want 17/15/17",
               pulses, err_cnt, blanks_ok);
    end
  endtask

  task automatic test_steady();
    int nv = 0;
    dig_ready = 1'b1;
    seg = 7'b1101101;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL steady i=%0d got=%b want=%b", i, obs, exp_vec());
      end
      if (dig_valid === 1'b1) nv++;
    end
    checks++;
    if (nv != 1) begin
      errors++;
      $display("FAIL steady_count pulses=%0d want=1", nv);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    int kind;
    logic [0:6] p;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 8);
        kind = $urandom_range(0, 9);
        if (kind <= 6) begin
          seg = tbl[$urandom_range(0, 9)];
        end else if (kind == 7) begin
          seg = 7'b0000000;
        end else if (kind == 8) begin
          p = 7'($urandom);
          if (classify(p) != 11) p = 7'b1000001;
          seg = p;
        end
      end
      hold--;
      dig_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 149) != 0);
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random i=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_active_low();
    dig_ready = 1'b0;
    seg1 = 7'b0000001;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL al_dut0 i=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
    checks++;
    if (obs1 !== 11'b0000_1_0_0_0000) begin
      errors++;
      $display("FAIL al_zero got=%b want=%b", obs1, 11'b0000_1_0_0_0000);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (obs1 !== 11'b0000_0_1_0_0000) begin
      errors++;
      $display("FAIL al_reset got=%b want=%b", obs1,
               11'b0000_0_1_0_0000);
    end
    checks++;
    if (obs !== 11'b0000_0_1_0_0000) begin
      errors++;
      $display("FAIL mid_reset got=%b want=%b", obs,
               11'b0000_0_1_0_0000);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_glitch();
    test_back_to_back();
    test_bad();
    test_steady();
    test_random();
    test_active_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
